xip_line_buffer: RTL and testbench

- Parametrised read-line buffer between the AXI-Lite XIP read channel and qspi_fsm/fifo_rx.
- On a miss it fetches a whole line of LINE_WORDS 32-bit words with one QSPI fast read, in 3- or 4-byte address mode.
- It serves hits from NUM_LINES fully-associative lines, so repeated and sequential XIP reads avoid per-word QSPI transactions.
- Supersedes the single-word read path of xip_engine.

---
 rtl/xip_line_buffer_pkg.sv | 23 ++
 rtl/xip_line_buffer_if.sv | 22 ++
 rtl/xip_line_buffer_store.sv | 75 +++++++
 rtl/xip_line_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_xip_line_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xip_line_buffer_pkg.sv
// rtl/xip_line_buffer_pkg.sv - shared state encodings, address modes and response codes for the XIP line buffer
package xip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOOKUP      = 3'd1,
        ST_FETCH_START = 3'd2,
        ST_FILL        = 3'd3,
        ST_RESP        = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_MODE_3B = 2'b01;
    localparam logic [1:0] ADDR_MODE_4B = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // In 3-byte mode the top address byte is not part of the flash address.
    function automatic logic [31:0] eff_addr(input logic [31:0] a, input logic [1:0] mode);
        return (mode == ADDR_MODE_3B) ? {8'h00, a[23:0]} : a;
    endfunction

endpackage

// File: rtl/xip_line_buffer_if.sv
// rtl/xip_line_buffer_if.sv - AXI-Lite XIP read channel (AR + R) bundle
// Ports: araddr_i/arvalid_i/rready_i driven by the master; arready_o,
// rdata_o/rresp_o/rvalid_o driven by the line buffer (slave).
interface xip_line_buffer_if;
    logic [31:0] araddr_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i;

    modport master (
        output araddr_i, arvalid_i, rready_i,
        input  arready_o, rdata_o, rresp_o, rvalid_o
    );

    modport slave (
        input  araddr_i, arvalid_i, rready_i,
        output arready_o, rdata_o, rresp_o, rvalid_o
    );
endinterface

// File: rtl/xip_line_buffer_store.sv
// rtl/xip_line_buffer_store.sv - fully-associative line array with tag/valid and one write port
// Ports: lookup_tag -> hit/hit_line (combinational), valid vector out,
// rd_line/rd_word -> rd_data (combinational), word write port (wr_*),
// tag write at fill end (tag_we/tag_data/set_valid on wr_line), inv_all clears every valid bit.
module xip_line_store #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4,
    parameter int TAG_W      = 28,
    localparam int WIDX_W    = $clog2(LINE_WORDS),
    localparam int LIDX_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [TAG_W-1:0]     lookup_tag,
    output logic                 hit,
    output logic [LIDX_W-1:0]    hit_line,
    output logic [NUM_LINES-1:0] valid,
    input  logic [LIDX_W-1:0]    rd_line,
    input  logic [WIDX_W-1:0]    rd_word,
    output logic [31:0]          rd_data,
    input  logic                 wr_en,
    input  logic [LIDX_W-1:0]    wr_line,
    input  logic [WIDX_W-1:0]    wr_word,
    input  logic [31:0]          wr_data,
    input  logic                 tag_we,
    input  logic [TAG_W-1:0]     tag_data,
    input  logic                 set_valid,
    input  logic                 inv_all
);

    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    assign valid   = valid_q;
    assign rd_data = data_q[rd_line][rd_word];

    // Lowest matching line wins; tags are unique among valid lines anyway.
    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!hit && valid_q[i] && (tag_q[i] == lookup_tag)) begin
                hit      = 1'b1;
                hit_line = LIDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_line][wr_word] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            if (tag_we) begin
                tag_q[wr_line] <= tag_data;
            end
            // Invalidate wins over a fill completing in the same cycle.
            if (inv_all) begin
                valid_q <= '0;
            end else if (tag_we) begin
                valid_q[wr_line] <= set_valid;
            end
        end
    end

endmodule

// File: rtl/xip_line_buffer.sv
// rtl/xip_line_buffer.sv - XIP read-line buffer between the AXI-Lite read channel and qspi_fsm/fifo_rx
// Ports: clk/resetn; xip_en_i, xip_addr_bytes_i, flush_i controls; axi (slave modport,
// AR/R channel); start_o/addr_o/len_o/done_i to qspi_fsm; rx_data_i/rx_empty_i/rx_re_o
// to fifo_rx; busy_o; saturating hit_cnt_o/miss_cnt_o.
module xip_line_buffer
    import xip_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               xip_en_i,
    input  logic [1:0]         xip_addr_bytes_i,
    input  logic               flush_i,
    xip_line_buffer_if.slave   axi,
    output logic               start_o,
    output logic [31:0]        addr_o,
    output logic [31:0]        len_o,
    input  logic               done_i,
    input  logic [31:0]        rx_data_i,
    input  logic               rx_empty_i,
    output logic               rx_re_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   hit_cnt_o,
    output logic [CNT_W-1:0]   miss_cnt_o
);

    localparam int WIDX_W     = $clog2(LINE_WORDS);
    localparam int OFF_W      = WIDX_W + 2;
    localparam int TAG_W      = 32 - OFF_W;
    localparam int LIDX_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int LINE_BYTES = LINE_WORDS * 4;

    state_t               state_q, state_d;
    logic                 init_q;
    logic [31:0]          addr_q;
    logic [1:0]           mode_q;
    logic [WIDX_W-1:0]    req_word_q;
    logic [LIDX_W-1:0]    victim_q;
    logic [LIDX_W-1:0]    rr_q;
    logic [31:0]          base_q;
    logic [31:0]          len_q;
    logic [WIDX_W:0]      fill_cnt_q;
    logic                 done_seen_q;
    logic                 flush_seen_q;
    logic [31:0]          rdata_q;
    logic [1:0]           rresp_q;
    logic [CNT_W-1:0]     hit_cnt_q;
    logic [CNT_W-1:0]     miss_cnt_q;

    logic [31:0]          eff;
    logic                 inv_all;
    logic                 st_hit;
    logic [LIDX_W-1:0]    st_hit_line;
    logic [NUM_LINES-1:0] st_valid;
    logic [31:0]          st_rd_data;
    logic                 hit_ok;
    logic [LIDX_W-1:0]    victim;
    logic                 pop;
    logic                 fill_done;
    logic                 unused_addr_lsb;

    assign eff             = eff_addr(addr_q, xip_addr_bytes_i);
    assign unused_addr_lsb = ^eff[1:0];
    // A mode change behaves exactly like a flush: lines fetched in the other mode are stale.
    assign inv_all         = flush_i || (xip_addr_bytes_i != mode_q);
    assign hit_ok          = st_hit && !inv_all;
    assign pop             = (state_q == ST_FILL) && !rx_empty_i
                             && (fill_cnt_q != (WIDX_W + 1)'(LINE_WORDS));
    assign fill_done       = (state_q == ST_FILL)
                             && (fill_cnt_q == (WIDX_W + 1)'(LINE_WORDS))
                             && (done_seen_q || done_i);

    always_comb begin
        logic found;
        found  = 1'b0;
        victim = rr_q;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!found && !st_valid[i]) begin
                found  = 1'b1;
                victim = LIDX_W'(i);
            end
        end
    end

    xip_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk        (clk),
        .resetn     (resetn),
        .lookup_tag (eff[31:OFF_W]),
        .hit        (st_hit),
        .hit_line   (st_hit_line),
        .valid      (st_valid),
        .rd_line    (st_hit_line),
        .rd_word    (eff[OFF_W-1:2]),
        .rd_data    (st_rd_data),
        .wr_en      (pop),
        .wr_line    (victim_q),
        .wr_word    (fill_cnt_q[WIDX_W-1:0]),
        .wr_data    (rx_data_i),
        .tag_we     (fill_done),
        .tag_data   (base_q[31:OFF_W]),
        .set_valid  (!(flush_seen_q || inv_all)),
        .inv_all    (inv_all)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (axi.arvalid_i && init_q) state_d = ST_LOOKUP;
            ST_LOOKUP:      state_d = (!xip_en_i || hit_ok) ? ST_RESP : ST_FETCH_START;
            ST_FETCH_START: state_d = ST_FILL;
            ST_FILL:        if (fill_done) state_d = ST_RESP;
            ST_RESP:        if (axi.rready_i) state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // init_q keeps arready_o low through reset and the first cycle after it.
    always_comb begin
        axi.arready_o = (state_q == ST_IDLE) && init_q;
        axi.rvalid_o  = (state_q == ST_RESP);
        axi.rdata_o   = rdata_q;
        axi.rresp_o   = rresp_q;
        start_o       = (state_q == ST_FETCH_START);
        busy_o        = (state_q == ST_FETCH_START) || (state_q == ST_FILL);
        rx_re_o       = pop;
        addr_o        = base_q;
        len_o         = len_q;
        hit_cnt_o     = hit_cnt_q;
        miss_cnt_o    = miss_cnt_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            init_q       <= 1'b0;
            addr_q       <= '0;
            mode_q       <= ADDR_MODE_4B;
            req_word_q   <= '0;
            victim_q     <= '0;
            rr_q         <= '0;
            base_q       <= '0;
            len_q        <= '0;
            fill_cnt_q   <= '0;
            done_seen_q  <= 1'b0;
            flush_seen_q <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            init_q <= 1'b1;
            mode_q <= xip_addr_bytes_i;
            // Remembers any invalidate between lookup and fill end so the new line stays invalid.
            if (inv_all) begin
                flush_seen_q <= 1'b1;
            end else if (state_q == ST_LOOKUP) begin
                flush_seen_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (axi.arvalid_i && init_q) begin
                        addr_q <= axi.araddr_i;
                    end
                end
                ST_LOOKUP: begin
                    if (!xip_en_i) begin
                        rdata_q <= '0;
                        rresp_q <= RESP_SLVERR;
                    end else if (hit_ok) begin
                        rdata_q <= st_rd_data;
                        rresp_q <= RESP_OKAY;
                        if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    end else begin
                        victim_q    <= victim;
                        req_word_q  <= eff[OFF_W-1:2];
                        base_q      <= {eff[31:OFF_W], {OFF_W{1'b0}}};
                        len_q       <= 32'(LINE_BYTES);
                        fill_cnt_q  <= '0;
                        done_seen_q <= 1'b0;
                        rresp_q     <= RESP_OKAY;
                        if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                    end
                end
                ST_FETCH_START: begin
                    if (done_i) done_seen_q <= 1'b1;
                end
                ST_FILL: begin
                    if (done_i) done_seen_q <= 1'b1;
                    if (pop) begin
                        fill_cnt_q <= fill_cnt_q + (WIDX_W + 1)'(1);
                        if (fill_cnt_q[WIDX_W-1:0] == req_word_q) rdata_q <= rx_data_i;
                    end
                    if (fill_done) begin
                        rr_q <= (rr_q == LIDX_W'(NUM_LINES - 1)) ? '0 : rr_q + LIDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xip_line_buffer.sv
// tb/tb_xip_line_buffer.sv - self-checking bench for xip_line_buffer
module tb_xip_line_buffer;
    import xip_pkg::*;

    localparam int LW = 4;
    localparam int NL = 2;
    localparam int CW = 16;
    localparam int LB = LW * 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          xip_en_i = 1'b1;
    logic [1:0]    xip_addr_bytes_i = ADDR_MODE_4B;
    logic          flush_main = 1'b0;
    logic          flush_resp = 1'b0;
    logic          flush_i;
    logic          start_o;
    logic [31:0]   addr_o;
    logic [31:0]   len_o;
    logic          done_i = 1'b0;
    logic [31:0]   rx_data_i;
    logic          rx_empty_i;
    logic          rx_re_o;
    logic          busy_o;
    logic [CW-1:0] hit_cnt_o;
    logic [CW-1:0] miss_cnt_o;

    xip_line_buffer_if axi ();

    assign flush_i = flush_main | flush_resp;

    always #5 clk = ~clk;

    xip_line_buffer #(.LINE_WORDS(LW), .NUM_LINES(NL), .CNT_W(CW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .xip_en_i         (xip_en_i),
        .xip_addr_bytes_i (xip_addr_bytes_i),
        .flush_i          (flush_i),
        .axi              (axi),
        .start_o          (start_o),
        .addr_o           (addr_o),
        .len_o            (len_o),
        .done_i           (done_i),
        .rx_data_i        (rx_data_i),
        .rx_empty_i       (rx_empty_i),
        .rx_re_o          (rx_re_o),
        .busy_o           (busy_o),
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Flash device: erased, or word n holds 0xA5000000+n.
    bit pattern = 1'b0;
    function automatic logic [31:0] flash_word(input logic [31:0] a);
        return pattern ? (32'hA500_0000 + {2'b00, a[31:2]}) : 32'hFFFF_FFFF;
    endfunction

    // fifo_rx stand-in
    logic [31:0] rx_mem [64];
    int rx_wp = 0;
    int rx_rp = 0;
    assign rx_empty_i = (rx_wp == rx_rp);
    assign rx_data_i  = rx_mem[rx_rp % 64];
    always @(posedge clk) if (rx_re_o && (rx_wp != rx_rp)) rx_rp <= rx_rp + 1;

    // qspi_fsm stand-in: one word per cycle after start_o, then done (or done after the first word).
    bit flush_in_fill = 1'b0;
    bit done_early = 1'b0;
    initial begin
        int nw;
        logic [31:0] fb;
        forever begin
            @(negedge clk);
            if (start_o) begin
                nw = int'(len_o) / 4;
                fb = addr_o;
                for (int k = 0; k < nw; k++) begin
                    @(negedge clk);
                    rx_mem[rx_wp % 64] = flash_word(fb + 32'(4 * k));
                    rx_wp = rx_wp + 1;
                    flush_resp = flush_in_fill && (k == 1);
                    done_i = done_early && (k == 0);
                end
                @(negedge clk);
                flush_resp = 1'b0;
                if (!done_early) begin
                    done_i = 1'b1;
                    @(negedge clk);
                end
                done_i = 1'b0;
            end
        end
    end

    // Model state and current expectations
    int          m_hits = 0;
    int          m_misses = 0;
    logic [31:0] m_tag [NL];
    bit          m_valid [NL];
    int          m_rr = 0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_rresp = RESP_OKAY;
    logic [31:0] exp_addr = '0;
    int          n_starts = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_len = '0;

    always @(negedge clk) begin
        if (resetn) begin
            if (axi.rvalid_o) begin
                check("rdata", axi.rdata_o, exp_rdata);
                check("rresp", {30'b0, axi.rresp_o}, {30'b0, exp_rresp});
            end
            if (start_o) begin
                n_starts++;
                last_addr = addr_o;
                last_len  = len_o;
            end
            if (busy_o) begin
                check("fetch_addr", addr_o, exp_addr);
                check("fetch_len", len_o, 32'(LB));
            end
            if (rx_re_o) check("pop_nonempty", {31'b0, rx_empty_i}, 32'd0);
        end
    end

    task automatic model_invalidate();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    logic [31:0] last_rdata;
    int          last_lat;
    int          last_starts;

    task automatic do_read(input logic [31:0] a, input int hold, input bit fl, input bit de);
        logic [31:0] e;
        logic [31:0] base;
        logic [31:0] d;
        logic [1:0]  r;
        bit          hit;
        bit          fetch;
        int          v;
        int          s0;
        int          c0;
        int          t;
        e     = (xip_addr_bytes_i == ADDR_MODE_3B) ? (a & 32'h00FF_FFFF) : a;
        base  = e & ~32'(LB - 1);
        hit   = 1'b0;
        fetch = 1'b0;
        if (!xip_en_i) begin
            exp_rdata = '0;
            exp_rresp = RESP_SLVERR;
        end else begin
            exp_rdata = flash_word(e);
            exp_rresp = RESP_OKAY;
            for (int i = 0; i < NL; i++) if (m_valid[i] && m_tag[i] == base) hit = 1'b1;
            if (hit) begin
                if (m_hits < (1 << CW) - 1) m_hits++;
            end else begin
                if (m_misses < (1 << CW) - 1) m_misses++;
                fetch    = 1'b1;
                exp_addr = base;
                v = -1;
                for (int i = 0; i < NL; i++) if (!m_valid[i] && v < 0) v = i;
                if (v < 0) v = m_rr;
                if (fl) model_invalidate();
                else begin
                    m_valid[v] = 1'b1;
                    m_tag[v]   = base;
                end
                m_rr = (m_rr + 1) % NL;
            end
        end
        flush_in_fill = fl;
        done_early    = de;
        s0 = n_starts;
        @(negedge clk);
        axi.araddr_i  = a;
        axi.arvalid_i = 1'b1;
        t = 0;
        while (!axi.arready_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ar_handshake", {31'b0, axi.arready_o}, 32'd1);
        c0 = cyc;
        @(negedge clk);
        axi.arvalid_i = 1'b0;
        t = 0;
        while (!axi.rvalid_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rvalid_seen", {31'b0, axi.rvalid_o}, 32'd1);
        last_lat   = cyc - c0;
        last_rdata = axi.rdata_o;
        if (hit) check("hit_latency", 32'(last_lat), 32'd2);
        d = axi.rdata_o;
        r = axi.rresp_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rvalid", {31'b0, axi.rvalid_o}, 32'd1);
            check("hold_rdata", axi.rdata_o, d);
            check("hold_rresp", {30'b0, axi.rresp_o}, {30'b0, r});
        end
        axi.rready_i = 1'b1;
        @(negedge clk);
        axi.rready_i = 1'b0;
        check("rvalid_drop", {31'b0, axi.rvalid_o}, 32'd0);
        last_starts = n_starts - s0;
        check("start_count", 32'(last_starts), {31'b0, fetch});
        check("hit_cnt", {16'b0, hit_cnt_o}, 32'(m_hits));
        check("miss_cnt", {16'b0, miss_cnt_o}, 32'(m_misses));
        flush_in_fill = 1'b0;
        done_early    = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_main = 1'b1;
        @(negedge clk);
        flush_main = 1'b0;
        model_invalidate();
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        xip_addr_bytes_i = m;
        model_invalidate();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.araddr_i  = '0;
        axi.arvalid_i = 1'b0;
        axi.rready_i  = 1'b0;
        model_invalidate();
        repeat (3) @(negedge clk);
        check("rst_arready", {31'b0, axi.arready_o}, 32'd0);
        check("rst_rvalid", {31'b0, axi.rvalid_o}, 32'd0);
        check("rst_start", {31'b0, start_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_rx_re", {31'b0, rx_re_o}, 32'd0);
        check("rst_counts", {hit_cnt_o, miss_cnt_o}, 32'd0);
        check("rst_addr_len", addr_o | len_o, 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Erased device, one fill then three hits in the same line.
        do_read(32'h0, 0, 1'b0, 1'b0);
        check("t1_data", last_rdata, 32'hFFFF_FFFF);
        check("t1_addr", last_addr, 32'h0);
        check("t1_len", last_len, 32'd16);
        do_read(32'h4, 0, 1'b0, 1'b0);
        do_read(32'h8, 0, 1'b0, 1'b0);
        do_read(32'hC, 0, 1'b0, 1'b0);
        check("t1_hits", {16'b0, hit_cnt_o}, 32'd3);
        check("t1_misses", {16'b0, miss_cnt_o}, 32'd1);

        // Patterned device; done arrives before the words.
        pulse_flush();
        pattern = 1'b1;
        do_read(32'h1C, 0, 1'b0, 1'b1);
        check("t2_addr", last_addr, 32'h10);
        check("t2_data", last_rdata, 32'hA500_0007);
        do_read(32'h1C, 0, 1'b0, 1'b0);
        check("t2_lat", 32'(last_lat), 32'd2);

        // 3-byte mode ignores the top byte; mode switch invalidates.
        set_mode(ADDR_MODE_3B);
        do_read(32'hFF00_0020, 0, 1'b0, 1'b0);
        check("t3_addr", last_addr, 32'h20);
        check("t3_data", last_rdata, 32'hA500_0008);
        do_read(32'h0000_0020, 0, 1'b0, 1'b0);
        check("t3_hit", 32'(last_starts), 32'd0);
        set_mode(ADDR_MODE_4B);
        do_read(32'h20, 0, 1'b0, 1'b0);
        check("t3_remiss", 32'(last_starts), 32'd1);

        // Two lines: third distinct line evicts the first.
        pulse_flush();
        do_read(32'h00, 0, 1'b0, 1'b0);
        do_read(32'h10, 0, 1'b0, 1'b0);
        do_read(32'h20, 0, 1'b0, 1'b0);
        do_read(32'h00, 0, 1'b0, 1'b0);
        check("t4_evict", 32'(last_starts), 32'd1);
        check("t4_evict_addr", last_addr, 32'h00);

        // Flush during fill: data still correct, line not kept.
        do_read(32'h44, 0, 1'b1, 1'b0);
        check("t5_data", last_rdata, 32'hA500_0011);
        do_read(32'h44, 0, 1'b0, 1'b0);
        check("t5_remiss", 32'(last_starts), 32'd1);

        // XIP disabled: SLVERR, no fetch, stable response under back-pressure.
        @(negedge clk);
        xip_en_i = 1'b0;
        do_read(32'h44, 5, 1'b0, 1'b0);
        check("t6_resp_data", last_rdata, 32'h0);
        check("t6_nostart", 32'(last_starts), 32'd0);
        @(negedge clk);
        xip_en_i = 1'b1;
        do_read(32'h48, 3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
